// File: rtl/m_trap_pkg.sv
// Shared constants and types for the machine-mode trap sequencer.
package m_trap_pkg;

  // XLEN width codes: W = 1 << (code + 4)
  localparam logic [1:0] XLEN_64b = 2'd2;

  // Cause code meaning "no exception" (10 is reserved in the M-mode cause space)
  localparam logic [3:0] NO_E     = 4'd10;
  localparam logic [3:0] MEI_CODE = 4'd11;
  localparam logic [3:0] MSI_CODE = 4'd3;

  // mstatus / mie bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;  // two-bit field [12:11]
  localparam int MIE_MSIE     = 3;
  localparam int MIE_MEIE     = 11;

  // mtvec mode field value for vectored interrupts
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_EPC     = 3'd1,
    S_W_CAUSE   = 3'd2,
    S_W_TVAL    = 3'd3,
    S_W_MSTATUS = 3'd4,
    S_REDIRECT  = 3'd5
  } trap_state_e;

  // One selected trap event out of the priority encoder
  typedef struct packed {
    logic        valid;
    logic        is_int;
    logic        is_mret;
    logic [3:0]  code;
    logic [31:0] epc;
    logic [31:0] tval;
  } trap_evt_t;

endpackage

// File: rtl/m_trap_prio_encoder.sv
// Combinational selection of the single highest-priority trap source:
// E/M exception > F/D exception > external irq > software irq > mret.
module m_trap_prio_encoder
  import m_trap_pkg::*;
(
  input  logic [3:0]  i_exc_code_fd,
  input  logic [31:0] i_exc_pc_fd,
  input  logic [3:0]  i_exc_code_em,
  input  logic [31:0] i_exc_pc_em,
  input  logic [31:0] i_exc_addr_em,
  input  logic        i_mret_e,
  input  logic        i_meip,
  input  logic        i_msip,
  input  logic [31:0] i_int_pc,
  input  logic        i_mstatus_mie,
  input  logic        i_mie_meie,
  input  logic        i_mie_msie,
  output trap_evt_t   o_evt
);

  // Priority chain; interrupts additionally need the global and per-source enables
  always_comb begin
    o_evt = '0;
    if (i_exc_code_em != NO_E) begin
      o_evt.valid = 1'b1;
      o_evt.code  = i_exc_code_em;
      o_evt.epc   = i_exc_pc_em;
      o_evt.tval  = i_exc_addr_em;
    end else if (i_exc_code_fd != NO_E) begin
      o_evt.valid = 1'b1;
      o_evt.code  = i_exc_code_fd;
      o_evt.epc   = i_exc_pc_fd;
      o_evt.tval  = i_exc_pc_fd;
    end else if (i_meip && i_mstatus_mie && i_mie_meie) begin
      o_evt.valid  = 1'b1;
      o_evt.is_int = 1'b1;
      o_evt.code   = MEI_CODE;
      o_evt.epc    = i_int_pc;
    end else if (i_msip && i_mstatus_mie && i_mie_msie) begin
      o_evt.valid  = 1'b1;
      o_evt.is_int = 1'b1;
      o_evt.code   = MSI_CODE;
      o_evt.epc    = i_int_pc;
    end else if (i_mret_e) begin
      o_evt.valid   = 1'b1;
      o_evt.is_mret = 1'b1;
    end
  end

endmodule

// File: rtl/m_trap_sequencer.sv
// Machine-mode trap sequencer: takes one trap/mret event, writes the
// affected CSRs one per cycle over the shared write port, then redirects
// fetch. While idle the pipeline's own CSR writes pass straight through.
module m_trap_sequencer
  import m_trap_pkg::*;
#(
  parameter  logic [1:0] XLEN = XLEN_64b,
  localparam int         W    = 1 << (int'(XLEN) + 4)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clk_en,
  input  logic [3:0]    i_exc_code_fd,
  input  logic [31:0]   i_exc_pc_fd,
  input  logic [3:0]    i_exc_code_em,
  input  logic [31:0]   i_exc_pc_em,
  input  logic [31:0]   i_exc_addr_em,
  input  logic          i_mret_e,
  input  logic          i_meip,
  input  logic          i_msip,
  input  logic [31:0]   i_int_pc,
  input  logic [W-1:0]  i_mstatus,
  input  logic [W-1:0]  i_mie,
  input  logic [W-1:0]  i_mtvec,
  input  logic [W-1:0]  i_mepc,
  input  logic          i_pipe_csr_we,
  input  logic [11:0]   i_pipe_csr_addr,
  input  logic [W-1:0]  i_pipe_csr_data,
  output logic          o_csr_we,
  output logic [11:0]   o_csr_addr,
  output logic [W-1:0]  o_csr_data,
  output logic          o_flush,
  output logic          o_stall,
  output logic          o_redirect_valid,
  output logic [31:0]   o_redirect_pc,
  output logic          o_busy
);

  trap_state_e r_state;
  logic        r_is_int;
  logic        r_is_mret;
  logic [3:0]  r_code;
  logic [31:0] r_epc;
  logic [31:0] r_tval;

  trap_evt_t   w_evt;
  logic [W-1:0] w_mstatus_trap;
  logic [W-1:0] w_mstatus_mret;
  logic [W-1:0] w_cause;
  logic [31:0]  w_tvec_base;
  logic [31:0]  w_trap_pc;
  logic         w_unused;

  // Only low 32 bits of mtvec/mepc form PCs; only two mie bits matter here
  assign w_unused = ^{i_mtvec, i_mepc, i_mie};

  m_trap_prio_encoder u_prio (
    .i_exc_code_fd (i_exc_code_fd),
    .i_exc_pc_fd   (i_exc_pc_fd),
    .i_exc_code_em (i_exc_code_em),
    .i_exc_pc_em   (i_exc_pc_em),
    .i_exc_addr_em (i_exc_addr_em),
    .i_mret_e      (i_mret_e),
    .i_meip        (i_meip),
    .i_msip        (i_msip),
    .i_int_pc      (i_int_pc),
    .i_mstatus_mie (i_mstatus[MSTATUS_MIE]),
    .i_mie_meie    (i_mie[MIE_MEIE]),
    .i_mie_msie    (i_mie[MIE_MSIE]),
    .o_evt         (w_evt)
  );

  // FSM and event latches; events are only sampled in IDLE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_is_int  <= 1'b0;
      r_is_mret <= 1'b0;
      r_code    <= 4'd0;
      r_epc     <= 32'd0;
      r_tval    <= 32'd0;
    end else if (i_clk_en) begin
      case (r_state)
        S_IDLE: begin
          if (w_evt.valid) begin
            r_is_int  <= w_evt.is_int;
            r_is_mret <= w_evt.is_mret;
            r_code    <= w_evt.code;
            r_epc     <= w_evt.epc;
            r_tval    <= w_evt.tval;
            r_state   <= w_evt.is_mret ? S_W_MSTATUS : S_W_EPC;
          end
        end
        S_W_EPC:     r_state <= S_W_CAUSE;
        S_W_CAUSE:   r_state <= S_W_TVAL;
        S_W_TVAL:    r_state <= S_W_MSTATUS;
        S_W_MSTATUS: r_state <= S_REDIRECT;
        S_REDIRECT:  r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  // Derived CSR write values and trap target
  always_comb begin
    w_mstatus_trap                      = i_mstatus;
    w_mstatus_trap[MSTATUS_MPIE]        = i_mstatus[MSTATUS_MIE];
    w_mstatus_trap[MSTATUS_MIE]         = 1'b0;
    w_mstatus_trap[MSTATUS_MPP +: 2]    = 2'b11;
    w_mstatus_mret                      = i_mstatus;
    w_mstatus_mret[MSTATUS_MIE]         = i_mstatus[MSTATUS_MPIE];
    w_mstatus_mret[MSTATUS_MPIE]        = 1'b1;
    w_mstatus_mret[MSTATUS_MPP +: 2]    = 2'b11;
    w_cause                             = '0;
    w_cause[W-1]                        = r_is_int;
    w_cause[3:0]                        = r_code;
    w_tvec_base = i_mtvec[31:0] & ~32'h3;
    if ((i_mtvec[1:0] == MTVEC_VECTORED) && r_is_int)
      w_trap_pc = w_tvec_base + {26'd0, r_code, 2'b00};
    else
      w_trap_pc = w_tvec_base;
  end

  // Output decode: pass-through in IDLE, one CSR write per trap state
  always_comb begin
    o_csr_we         = 1'b0;
    o_csr_addr       = 12'd0;
    o_csr_data       = '0;
    o_flush          = 1'b0;
    o_stall          = 1'b1;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_evt.valid) begin
          o_flush = 1'b1;
        end else begin
          o_stall    = 1'b0;
          o_csr_we   = i_pipe_csr_we;
          o_csr_addr = i_pipe_csr_addr;
          o_csr_data = i_pipe_csr_data;
        end
      end
      S_W_EPC: begin
        o_csr_we   = 1'b1;
        o_csr_addr = CSR_MEPC;
        o_csr_data = W'(r_epc);
      end
      S_W_CAUSE: begin
        o_csr_we   = 1'b1;
        o_csr_addr = CSR_MCAUSE;
        o_csr_data = w_cause;
      end
      S_W_TVAL: begin
        o_csr_we   = 1'b1;
        o_csr_addr = CSR_MTVAL;
        o_csr_data = W'(r_tval);
      end
      S_W_MSTATUS: begin
        o_csr_we   = 1'b1;
        o_csr_addr = CSR_MSTATUS;
        o_csr_data = r_is_mret ? w_mstatus_mret : w_mstatus_trap;
      end
      S_REDIRECT: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = r_is_mret ? i_mepc[31:0] : w_trap_pc;
      end
      default: ;
    endcase
    // Pulses must not fire on a cycle where nothing advances
    if (!i_clk_en) begin
      o_csr_we         = 1'b0;
      o_flush          = 1'b0;
      o_redirect_valid = 1'b0;
    end
    // Hold every output low while reset is asserted
    if (!i_rst_n) begin
      o_csr_we         = 1'b0;
      o_csr_addr       = 12'd0;
      o_csr_data       = '0;
      o_flush          = 1'b0;
      o_stall          = 1'b0;
      o_redirect_valid = 1'b0;
      o_redirect_pc    = 32'd0;
    end
  end

  assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_m_trap_sequencer.sv
// Scoreboard bench for m_trap_sequencer: each scenario pushes the CSR
// writes and redirect it expects; a negedge monitor pops and compares.
module tb_m_trap_sequencer;
  import m_trap_pkg::*;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b1;
  logic [3:0]    exc_code_fd = NO_E;
  logic [31:0]   exc_pc_fd = '0;
  logic [3:0]    exc_code_em = NO_E;
  logic [31:0]   exc_pc_em = '0;
  logic [31:0]   exc_addr_em = '0;
  logic          mret_e = 1'b0;
  logic          meip = 1'b0;
  logic          msip = 1'b0;
  logic [31:0]   int_pc = '0;
  logic [W-1:0]  mstatus = '0;
  logic [W-1:0]  mie = '0;
  logic [W-1:0]  mtvec = '0;
  logic [W-1:0]  mepc = '0;
  logic          pipe_we = 1'b0;
  logic [11:0]   pipe_addr = '0;
  logic [W-1:0]  pipe_data = '0;
  logic          csr_we;
  logic [11:0]   csr_addr;
  logic [W-1:0]  csr_data;
  logic          flush;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          busy;

  m_trap_sequencer #(.XLEN(XLEN_64b)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en),
    .i_exc_code_fd(exc_code_fd), .i_exc_pc_fd(exc_pc_fd),
    .i_exc_code_em(exc_code_em), .i_exc_pc_em(exc_pc_em), .i_exc_addr_em(exc_addr_em),
    .i_mret_e(mret_e), .i_meip(meip), .i_msip(msip), .i_int_pc(int_pc),
    .i_mstatus(mstatus), .i_mie(mie), .i_mtvec(mtvec), .i_mepc(mepc),
    .i_pipe_csr_we(pipe_we), .i_pipe_csr_addr(pipe_addr), .i_pipe_csr_data(pipe_data),
    .o_csr_we(csr_we), .o_csr_addr(csr_addr), .o_csr_data(csr_data),
    .o_flush(flush), .o_stall(stall),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [11:0] addr; logic [W-1:0] data; } wr_t;
  typedef struct { logic [31:0] pc; int lat; } rd_t;
  wr_t wq[$];
  rd_t rq[$];
  int  det_cyc = 0;
  int  n_pass = 0;
  int  n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Monitor: every CSR write and redirect must match the head of its queue
  always @(negedge clk) begin
    wr_t ew;
    rd_t er;
    if (csr_we === 1'b1) begin
      chk("we_expected", 64'(csr_we), 64'(wq.size() != 0));
      if (wq.size() != 0) begin
        ew = wq.pop_front();
        chk("csr_addr", 64'(csr_addr), 64'(ew.addr));
        chk("csr_data", csr_data, ew.data);
      end
    end
    if (redirect_valid === 1'b1) begin
      chk("redirect_expected", 64'(redirect_valid), 64'(rq.size() != 0));
      if (rq.size() != 0) begin
        er = rq.pop_front();
        chk("redirect_pc", 64'(redirect_pc), 64'(er.pc));
        chk("redirect_lat", 64'(cyc - det_cyc), 64'(er.lat));
      end
    end
  end

  task automatic push_wr(input logic [11:0] a, input logic [W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] pc, input int lat);
    rd_t e;
    e.pc  = pc;
    e.lat = lat;
    rq.push_back(e);
  endtask

  task automatic push_trap(input logic [31:0] epc, input logic [W-1:0] cause,
                           input logic [31:0] tval, input logic [W-1:0] ms,
                           input logic [31:0] rpc, input int lat);
    push_wr(CSR_MEPC, W'(epc));
    push_wr(CSR_MCAUSE, cause);
    push_wr(CSR_MTVAL, W'(tval));
    push_wr(CSR_MSTATUS, ms);
    push_rd(rpc, lat);
  endtask

  task automatic clear_ev();
    exc_code_fd = NO_E;
    exc_code_em = NO_E;
    meip = 1'b0;
    msip = 1'b0;
    mret_e = 1'b0;
    pipe_we = 1'b0;
  endtask

  // Called at posedge+1 with the event inputs applied
  task automatic detect_cycle(input string tag);
    det_cyc = cyc;
    @(negedge clk);
    chk({tag, "_flush"}, 64'(flush), 64'd1);
    chk({tag, "_stall"}, 64'(stall), 64'd1);
    @(posedge clk); #1;
    clear_ev();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((wq.size() != 0 || rq.size() != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drain"}, 64'(wq.size() + rq.size()), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset: all outputs low even with a pipeline write request present
    pipe_we = 1'b1; pipe_addr = CSR_MSCRATCH; pipe_data = 64'h55;
    exc_code_em = 4'd5;
    #12;
    chk("rst_we", 64'(csr_we), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    clear_ev();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // E/M load fault; pipeline write in the detect cycle is dropped
    mstatus = 64'h2008; mtvec = 64'h200;
    exc_code_em = 4'd5; exc_pc_em = 32'h100; exc_addr_em = 32'h8004;
    pipe_we = 1'b1; pipe_addr = CSR_MSCRATCH; pipe_data = 64'hAA;
    push_trap(32'h100, 64'd5, 32'h8004, 64'h3880, 32'h200, 5);
    detect_cycle("em");
    chk("em_busy", 64'(busy), 64'd1);
    drain("em");

    // F/D and E/M together: E/M wins
    mstatus = 64'h0;
    exc_code_fd = 4'd2; exc_pc_fd = 32'h300;
    exc_code_em = 4'd4; exc_pc_em = 32'h120; exc_addr_em = 32'h9000;
    push_trap(32'h120, 64'd4, 32'h9000, 64'h1800, 32'h200, 5);
    detect_cycle("both");
    drain("both");

    // External interrupt, vectored mtvec
    mstatus = 64'h8; mie = 64'h800; mtvec = 64'h201; int_pc = 32'h400; meip = 1'b1;
    push_trap(32'h400, 64'h8000_0000_0000_000B, 32'h0, 64'h1880, 32'h22C, 5);
    detect_cycle("mei");
    drain("mei");

    // Interrupt pending but globally disabled: pass-through write
    mstatus = 64'h0; meip = 1'b1;
    pipe_we = 1'b1; pipe_addr = CSR_MSCRATCH; pipe_data = 64'hDEAD;
    push_wr(CSR_MSCRATCH, 64'hDEAD);
    @(negedge clk);
    chk("nomie_flush", 64'(flush), 64'd0);
    chk("nomie_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    clear_ev();
    chk("nomie_busy", 64'(busy), 64'd0);
    drain("nomie");

    // mret
    mstatus = 64'h80; mepc = 64'h104; mret_e = 1'b1;
    push_wr(CSR_MSTATUS, 64'h1888);
    push_rd(32'h104, 2);
    detect_cycle("mret");
    drain("mret");

    // Software interrupt, vectored; an E/M exception arriving mid-sequence is ignored
    mstatus = 64'h8; mie = 64'h8; mtvec = 64'h201; int_pc = 32'h500; msip = 1'b1;
    push_trap(32'h500, 64'h8000_0000_0000_0003, 32'h0, 64'h1880, 32'h20C, 5);
    detect_cycle("msi");
    exc_code_em = 4'd7; exc_pc_em = 32'h600; exc_addr_em = 32'h700;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exc_code_em = NO_E;
    drain("msi");

    // F/D exception with clock enable dropped for three cycles in W_CAUSE
    mstatus = 64'h0; mtvec = 64'h201;
    exc_code_fd = 4'd2; exc_pc_fd = 32'h300;
    push_trap(32'h300, 64'd2, 32'h300, 64'h1800, 32'h200, 8);
    detect_cycle("ce");
    @(posedge clk); #1;
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ce_we_low", 64'(csr_we), 64'd0);
      chk("ce_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    clk_en = 1'b1;
    drain("ce");

    // Asynchronous reset during W_CAUSE
    mstatus = 64'h8; mtvec = 64'h200;
    exc_code_em = 4'd6; exc_pc_em = 32'h140; exc_addr_em = 32'hA000;
    push_wr(CSR_MEPC, 64'h140);
    detect_cycle("rst");
    @(posedge clk); #1;
    chk("rst_mid_addr", 64'(csr_addr), 64'(CSR_MCAUSE));
    pipe_we = 1'b1; pipe_addr = CSR_MSCRATCH;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_we", 64'(csr_we), 64'd0);
    chk("rst_mid_addr0", 64'(csr_addr), 64'd0);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    chk("rst_mid_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_mid_wq", 64'(wq.size()), 64'd0);
    rq.delete();
    @(posedge clk); #1;
    clear_ev();
    rst_n = 1'b1;
    drain("rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
